// File: rtl/in_ep_scheduler.sv
// Routes the shared SIE IN-transaction handshake to one of N_EPS IN FIFOs,
// answering NAK/STALL and tracking per-endpoint DATA0/DATA1 and packet byte count.
module in_ep_scheduler #(
    parameter int N_EPS            = 4,
    parameter int IN_MAXPACKETSIZE = 8,
    localparam int CNT_W           = $clog2(IN_MAXPACKETSIZE + 1)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clk_gate_i,
    input  logic [3:0]         sie_in_ep_i,
    input  logic               sie_in_req_i,
    input  logic               sie_in_ready_i,
    input  logic               sie_in_data_ack_i,
    output logic [7:0]         sie_in_data_o,
    output logic               sie_in_valid_o,
    output logic               sie_in_nak_o,
    output logic               sie_in_stall_o,
    output logic               sie_in_toggle_o,
    output logic [N_EPS-1:0]   fifo_in_req_o,
    output logic [N_EPS-1:0]   fifo_in_ready_o,
    output logic [N_EPS-1:0]   fifo_in_data_ack_o,
    input  logic [8*N_EPS-1:0] fifo_in_data_i,
    input  logic [N_EPS-1:0]   fifo_in_valid_i,
    input  logic [N_EPS-1:0]   fifo_in_empty_i,
    input  logic [N_EPS-1:0]   ep_enable_i,
    input  logic [N_EPS-1:0]   ep_stall_i,
    input  logic [N_EPS-1:0]   toggle_clr_i,
    output logic [3:0]         active_ep_o,
    output logic [CNT_W-1:0]   byte_cnt_o
);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_ACK} state_t;

    state_t             state_q, state_d;
    logic [N_EPS-1:0]   sel_q, sel_d;       // selected endpoint kept one-hot
    logic [N_EPS-1:0]   tog_q, tog_d;
    logic [3:0]         active_ep_q, active_ep_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               nak_q, nak_d;
    logic               stall_q, stall_d;
    logic               pid_q, pid_d;

    logic [N_EPS-1:0]   ep_sel;
    logic               hit, stall_hit, empty_hit, sel_valid, gate_ok;
    logic [7:0]         sel_data;

    for (genvar gi = 0; gi < N_EPS; gi++) begin : g_decode
        assign ep_sel[gi] = (sie_in_ep_i == 4'(gi + 1));
    end

    assign hit       = |(ep_sel & ep_enable_i);
    assign stall_hit = |(ep_sel & ep_enable_i & ep_stall_i);
    assign empty_hit = |(ep_sel & ep_enable_i & fifo_in_empty_i);
    assign sel_valid = |(sel_q & fifo_in_valid_i);
    // Strobes are held off while reset is asserted so the FIFOs never move mid-reset.
    assign gate_ok   = clk_gate_i & rstn_i;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_EPS; i++) begin
            if (sel_q[i]) sel_data = sel_data | fifo_in_data_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d            = state_q;
        sel_d              = sel_q;
        tog_d              = tog_q;
        active_ep_d        = active_ep_q;
        byte_cnt_d         = byte_cnt_q;
        nak_d              = nak_q;
        stall_d            = stall_q;
        pid_d              = pid_q;
        fifo_in_req_o      = '0;
        fifo_in_ready_o    = '0;
        fifo_in_data_ack_o = '0;

        if (gate_ok && sie_in_req_i && sie_in_ready_i) begin
            nak_d   = 1'b0;
            stall_d = 1'b0;
            state_d = IDLE;
            if (stall_hit) begin
                stall_d = 1'b1;
            end else if (empty_hit) begin
                nak_d = 1'b1;
            end else if (hit) begin
                fifo_in_req_o = ep_sel;
                sel_d         = ep_sel;
                active_ep_d   = sie_in_ep_i;
                pid_d         = |(tog_q & ep_sel);
                byte_cnt_d    = '0;
                state_d       = XFER;
            end
        end else if (gate_ok && sie_in_ready_i && !sie_in_data_ack_i && state_q == XFER) begin
            fifo_in_ready_o = sel_q;
            if (sel_valid) begin
                if (byte_cnt_q != CNT_W'(IN_MAXPACKETSIZE)) byte_cnt_d = byte_cnt_q + 1'b1;
            end else begin
                state_d = WAIT_ACK;
            end
        end else if (gate_ok && sie_in_ready_i && sie_in_data_ack_i && state_q == WAIT_ACK) begin
            fifo_in_ready_o    = sel_q;
            fifo_in_data_ack_o = sel_q;
            tog_d              = tog_q ^ sel_q;
            state_d            = IDLE;
        end

        // A clear wins over an ACK flip landing on the same bit period.
        if (clk_gate_i) tog_d = tog_d & ~toggle_clr_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            tog_q       <= '0;
            active_ep_q <= '0;
            byte_cnt_q  <= '0;
            nak_q       <= 1'b0;
            stall_q     <= 1'b0;
            pid_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tog_q       <= tog_d;
            active_ep_q <= active_ep_d;
            byte_cnt_q  <= byte_cnt_d;
            nak_q       <= nak_d;
            stall_q     <= stall_d;
            pid_q       <= pid_d;
        end
    end

    assign sie_in_data_o   = (state_q != IDLE) ? sel_data : 8'd0;
    assign sie_in_valid_o  = (state_q != IDLE) && sel_valid;
    assign sie_in_nak_o    = nak_q;
    assign sie_in_stall_o  = stall_q;
    assign sie_in_toggle_o = pid_q;
    assign active_ep_o     = active_ep_q;
    assign byte_cnt_o      = byte_cnt_q;

endmodule

// File: tb/tb_in_ep_scheduler.sv
// Directed bench for in_ep_scheduler: a rewindable IN FIFO bank plus a packet-level
// model of NAK/STALL/toggle/byte-count behaviour, compared every cycle.
module tb_in_ep_scheduler;
    localparam int N   = 4;
    localparam int MPS = 8;
    localparam int CW  = $clog2(MPS + 1);

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          clk_gate_i = 1'b0;
    logic [3:0]    sie_in_ep_i = '0;
    logic          sie_in_req_i = 1'b0, sie_in_ready_i = 1'b0, sie_in_data_ack_i = 1'b0;
    logic [7:0]    sie_in_data_o;
    logic          sie_in_valid_o, sie_in_nak_o, sie_in_stall_o, sie_in_toggle_o;
    logic [N-1:0]  fifo_in_req_o, fifo_in_ready_o, fifo_in_data_ack_o;
    logic [8*N-1:0] fifo_in_data_i;
    logic [N-1:0]  fifo_in_valid_i, fifo_in_empty_i;
    logic [N-1:0]  ep_enable_i = '0, ep_stall_i = '0, toggle_clr_i = '0;
    logic [3:0]    active_ep_o;
    logic [CW-1:0] byte_cnt_o;

    in_ep_scheduler #(.N_EPS(N), .IN_MAXPACKETSIZE(MPS)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .clk_gate_i(clk_gate_i),
        .sie_in_ep_i(sie_in_ep_i), .sie_in_req_i(sie_in_req_i),
        .sie_in_ready_i(sie_in_ready_i), .sie_in_data_ack_i(sie_in_data_ack_i),
        .sie_in_data_o(sie_in_data_o), .sie_in_valid_o(sie_in_valid_o),
        .sie_in_nak_o(sie_in_nak_o), .sie_in_stall_o(sie_in_stall_o),
        .sie_in_toggle_o(sie_in_toggle_o),
        .fifo_in_req_o(fifo_in_req_o), .fifo_in_ready_o(fifo_in_ready_o),
        .fifo_in_data_ack_o(fifo_in_data_ack_o), .fifo_in_data_i(fifo_in_data_i),
        .fifo_in_valid_i(fifo_in_valid_i), .fifo_in_empty_i(fifo_in_empty_i),
        .ep_enable_i(ep_enable_i), .ep_stall_i(ep_stall_i), .toggle_clr_i(toggle_clr_i),
        .active_ep_o(active_ep_o), .byte_cnt_o(byte_cnt_o)
    );

    always #5 clk = ~clk;

    // IN FIFO bank: committed pointer moves on ACK, read pointer rewinds on each request.
    logic [7:0] mem [N][32];
    int wr_cnt [N];
    int cptr   [N];
    int rptr   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fifo_in_valid_i[i]      = rptr[i] < wr_cnt[i];
            fifo_in_empty_i[i]      = cptr[i] == wr_cnt[i];
            fifo_in_data_i[8*i +: 8] = fifo_in_valid_i[i] ? mem[i][rptr[i]] : 8'd0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_in_req_o[i])                             rptr[i] <= cptr[i];
            else if (fifo_in_data_ack_o[i])                   cptr[i] <= rptr[i];
            else if (fifo_in_ready_o[i] && fifo_in_valid_i[i]) rptr[i] <= rptr[i] + 1;
        end
    end

    task automatic load(input int i, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[i][wr_cnt[i]] = base + 8'(k);
            wr_cnt[i] = wr_cnt[i] + 1;
        end
    endtask

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: phase 0 = no packet, 1 = sending data, 2 = awaiting ACK.
    int       m_phase = 0, m_sel = 0, m_active = 0, m_cnt = 0;
    bit       m_nak = 0, m_stall = 0, m_pid = 0;
    bit [N-1:0] m_tog = '0;

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_active = 0; m_cnt = 0;
        m_nak = 0; m_stall = 0; m_pid = 0; m_tog = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("nak", 32'(sie_in_nak_o), 32'(m_nak));
            chk("stall", 32'(sie_in_stall_o), 32'(m_stall));
            chk("toggle", 32'(sie_in_toggle_o), 32'(m_pid));
            chk("active_ep", 32'(active_ep_o), 32'(m_active));
            chk("byte_cnt", 32'(byte_cnt_o), 32'(m_cnt));
            chk("sie_valid", 32'(sie_in_valid_o), (m_phase != 0) ? 32'(fifo_in_valid_i[m_sel]) : 32'd0);
            chk("sie_data", 32'(sie_in_data_o), (m_phase != 0) ? 32'(fifo_in_data_i[8*m_sel +: 8]) : 32'd0);
        end
    end

    // One bit period: inputs held 4 clocks, gate high only on the last one.
    task automatic step(input bit req, input bit rdy, input bit ack, input int ep, input logic [N-1:0] clr);
        logic [N-1:0] xr, xy, xa;
        bit hit;
        int n_phase, n_sel, n_active, n_cnt;
        bit n_nak, n_stall, n_pid;
        bit [N-1:0] n_tog;
        @(negedge clk);
        sie_in_req_i = req; sie_in_ready_i = rdy; sie_in_data_ack_i = ack;
        sie_in_ep_i = 4'(ep); toggle_clr_i = clr; clk_gate_i = 1'b0;
        #1;
        chk("ungated_strobes", 32'({fifo_in_req_o, fifo_in_ready_o, fifo_in_data_ack_o}), 32'd0);
        repeat (3) @(negedge clk);
        clk_gate_i = 1'b1;
        #1;
        xr = '0; xy = '0; xa = '0;
        n_phase = m_phase; n_sel = m_sel; n_active = m_active; n_cnt = m_cnt;
        n_nak = m_nak; n_stall = m_stall; n_pid = m_pid; n_tog = m_tog;
        hit = 1'b0;
        if (ep >= 1 && ep <= N) hit = ep_enable_i[ep-1];
        if (rstn_i) begin
            if (req && rdy) begin
                n_nak = 0; n_stall = 0; n_phase = 0;
                if (hit && ep_stall_i[ep-1]) n_stall = 1;
                else if (hit && fifo_in_empty_i[ep-1]) n_nak = 1;
                else if (hit) begin
                    xr[ep-1] = 1'b1; n_sel = ep - 1; n_active = ep;
                    n_pid = m_tog[ep-1]; n_cnt = 0; n_phase = 1;
                end
            end else if (rdy && !ack && m_phase == 1) begin
                xy[m_sel] = 1'b1;
                if (fifo_in_valid_i[m_sel]) n_cnt = (m_cnt < MPS) ? m_cnt + 1 : MPS;
                else n_phase = 2;
            end else if (rdy && ack && m_phase == 2) begin
                xy[m_sel] = 1'b1; xa[m_sel] = 1'b1;
                n_tog[m_sel] = ~n_tog[m_sel]; n_phase = 0;
            end
            n_tog = n_tog & ~clr;
        end
        chk("fifo_req", 32'(fifo_in_req_o), 32'(xr));
        chk("fifo_ready", 32'(fifo_in_ready_o), 32'(xy));
        chk("fifo_ack", 32'(fifo_in_data_ack_o), 32'(xa));
        @(posedge clk);
        #1;
        clk_gate_i = 1'b0;
        if (rstn_i) begin
            m_phase = n_phase; m_sel = n_sel; m_active = n_active; m_cnt = n_cnt;
            m_nak = n_nak; m_stall = n_stall; m_pid = n_pid; m_tog = n_tog;
        end
        $display("[TB] req=%0b rdy=%0b ack=%0b ep=%0d clr=%b -> nak=%0b stall=%0b pid=%0b cnt=%0d data=%h",
                 req, rdy, ack, ep, clr, sie_in_nak_o, sie_in_stall_o, sie_in_toggle_o, byte_cnt_o, sie_in_data_o);
    endtask

    task automatic do_req(input int ep); step(1, 1, 0, ep, '0); endtask
    task automatic do_rdy(input int n); for (int k = 0; k < n; k++) step(0, 1, 0, 0, '0); endtask
    task automatic do_ack(input logic [N-1:0] clr); step(0, 1, 1, 0, clr); endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_active", 32'(active_ep_o), 32'd0);
        chk("rst_outputs", 32'({sie_in_nak_o, sie_in_stall_o, sie_in_toggle_o, sie_in_valid_o}), 32'd0);
        @(posedge clk); #2 rstn_i = 1'b1;
        ep_enable_i = 4'b1111;

        // EP1: three bytes, four readys, ack
        load(0, 8'hA1, 3);
        do_req(1);
        chk("ep1_first_byte", 32'(sie_in_data_o), 32'hA1);
        chk("ep1_active", 32'(active_ep_o), 32'd1);
        do_rdy(3);
        chk("ep1_cnt3", 32'(byte_cnt_o), 32'd3);
        chk("ep1_valid_end", 32'(sie_in_valid_o), 32'd0);
        do_rdy(1);
        do_ack('0);
        chk("ep1_fifo_empty", 32'(fifo_in_empty_i[0]), 32'd1);

        // EP2 empty -> NAK; disabled EP2 -> silent
        do_req(2);
        chk("ep2_nak", 32'(sie_in_nak_o), 32'd1);
        ep_enable_i = 4'b1101;
        do_req(2);
        chk("ep2_disabled_nak", 32'(sie_in_nak_o), 32'd0);
        ep_enable_i = 4'b1111;

        // EP3 stalled, then out-of-range endpoint
        load(2, 8'h30, 1);
        ep_stall_i = 4'b0100;
        do_req(3);
        chk("ep3_stall", 32'(sie_in_stall_o), 32'd1);
        ep_stall_i = 4'b0000;
        do_req(7);
        chk("ep7_stall_clear", 32'(sie_in_stall_o), 32'd0);

        // EP4 without ACK: retry resends the same bytes on DATA0
        load(3, 8'hB1, 2);
        do_req(4);
        do_rdy(3);
        do_req(4);
        chk("retry_data", 32'(sie_in_data_o), 32'hB1);
        chk("retry_pid", 32'(sie_in_toggle_o), 32'd0);
        do_rdy(3);
        do_ack('0);
        load(3, 8'hB3, 1);
        do_req(4);
        chk("ep4_pid_after_ack", 32'(sie_in_toggle_o), 32'd1);
        do_rdy(2);
        do_ack('0);

        // Byte counter saturates at max packet size
        load(3, 8'h10, 10);
        do_req(4);
        do_rdy(10);
        chk("cnt_saturate", 32'(byte_cnt_o), 32'(MPS));
        do_rdy(1);
        do_ack('0);

        // Interleaved EP1 / EP2
        load(0, 8'hC1, 2);
        load(1, 8'hD1, 2);
        do_req(1);
        chk("il_ep1_pid", 32'(sie_in_toggle_o), 32'd1);
        do_rdy(3);
        do_ack('0);
        do_req(2);
        chk("il_ep2_data", 32'(sie_in_data_o), 32'hD1);
        chk("il_ep2_pid", 32'(sie_in_toggle_o), 32'd0);
        do_rdy(3);
        do_ack('0);

        // Toggle clear coincident with ACK keeps DATA0
        load(0, 8'hE1, 1);
        do_req(1);
        chk("clr_pre_pid", 32'(sie_in_toggle_o), 32'd0);
        do_rdy(2);
        do_ack(4'b0001);
        load(0, 8'hE2, 1);
        do_req(1);
        chk("clr_pid", 32'(sie_in_toggle_o), 32'd0);
        do_rdy(2);
        do_ack('0);

        // Reset during XFER
        load(0, 8'hF1, 2);
        do_req(1);
        do_rdy(1);
        @(posedge clk); #2 rstn_i = 1'b0;
        model_reset();
        step(1, 1, 0, 1, '0);
        chk("rst_mid_active", 32'(active_ep_o), 32'd0);
        chk("rst_mid_cnt", 32'(byte_cnt_o), 32'd0);
        @(posedge clk); #2 rstn_i = 1'b1;
        do_req(1);
        chk("post_rst_pid", 32'(sie_in_toggle_o), 32'd0);
        chk("post_rst_data", 32'(sie_in_data_o), 32'hF1);
        do_rdy(3);
        do_ack('0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
